// File: rtl/divu_pkg.sv
// Shared constants and state encoding for the divu sequential divider.
// The optional divide-by-zero flag is enabled with the DIVU_DBZ_FLAG_EN macro.
package divu_pkg;

    localparam int DIVU_WIDTH = 32;
    localparam int DIVU_CNT_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } divu_state_t;

    localparam logic [DIVU_WIDTH-1:0] DIVU_DBZ_QUOT = '1;

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, and record the resulting quotient bit.
module divu_step
    import divu_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] d_ext;

    // R never exceeds D, so its top bit is always zero and is shifted out.
    logic unused_r_msb;
    assign unused_r_msb = r_i[WIDTH];

    always_comb begin
        t     = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
        d_ext = {1'b0, d_i};
        if (t >= d_ext) begin
            r_o = t - d_ext;
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            r_o = t;
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divu.sv
// Sequential unsigned divider, one quotient bit per clock (restoring radix-2).
// Define DIVU_DBZ_FLAG_EN to add the div_by_zero output flag.
module divu
    import divu_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             doDiv,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_done
`ifdef DIVU_DBZ_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam logic [DIVU_CNT_W-1:0] LAST_STEP = DIVU_CNT_W'(WIDTH - 1);

    divu_state_t            state_q, state_d;
    logic [DIVU_CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]         r_q, r_d;
    logic [WIDTH-1:0]       qw_q, qw_d;
    logic [WIDTH-1:0]       dv_q, dv_d;
    logic [WIDTH-1:0]       quot_q, quot_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic                   done_q, done_d;
    logic                   dbz_q, dbz_d;
    logic [WIDTH:0]         r_n;
    logic [WIDTH-1:0]       q_n;

    divu_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (qw_q),
        .d_i (dv_q),
        .r_o (r_n),
        .q_o (q_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        qw_d    = qw_q;
        dv_d    = dv_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (doDiv) begin
                    if (b != '0) begin
                        qw_d    = a;
                        dv_d    = b;
                        r_d     = '0;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        dbz_d   = 1'b0;
                        state_d = BUSY;
                    end else begin
                        // Divide-by-zero completes on the accepting edge.
                        quot_d = WIDTH'(DIVU_DBZ_QUOT);
                        rem_d  = a;
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end
                end
            end
            BUSY: begin
                r_d   = r_n;
                qw_d  = q_n;
                cnt_d = cnt_q + DIVU_CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    quot_d  = q_n;
                    rem_d   = r_n[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working registers are only meaningful in BUSY and are reloaded on accept.
    always_ff @(posedge clk) begin
        r_q  <= r_d;
        qw_q <= qw_d;
        dv_q <= dv_d;
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_done  = done_q;

`ifdef DIVU_DBZ_FLAG_EN
    assign div_by_zero = dbz_q;
`else
    logic unused_dbz;
    assign unused_dbz = dbz_q;
`endif

endmodule

// File: tb/tb_divu.sv
// Directed and random checks of divu against a quotient/remainder scoreboard.
module tb_divu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         doDiv;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_done;
`ifdef DIVU_DBZ_FLAG_EN
    logic         div_by_zero;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;
    exp_t sb[$];

    divu dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .doDiv     (doDiv),
        .quotient  (quotient),
        .remainder (remainder),
        .div_done  (div_done)
`ifdef DIVU_DBZ_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        if (bv == '0) begin
            e.q = '1;
            e.r = av;
        end else begin
            e.q = av / bv;
            e.r = av % bv;
        end
        sb.push_back(e);
        a = av;
        b = bv;
        doDiv = 1'b1;
        tick();
        doDiv = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_quot"}, quotient, e.q);
            chk({tag, "_rem"}, remainder, e.r);
        end
    endtask

    // Waits for div_done; 'elapsed' edges since acceptance are already spent.
    task automatic wait_done(input string tag, input int elapsed, input logic [W-1:0] held_q);
        int n = elapsed;
        while (!div_done && n < 40) begin
            if (quotient !== held_q) chk({tag, "_held"}, quotient, held_q);
            tick();
            n++;
        end
        chk({tag, "_latency"}, W'(n), W'(32));
        compare_result(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb, prev_q;
        reset = 1'b1;
        doDiv = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_quot", quotient, '0);
        chk("rst_rem", remainder, '0);
        chk("rst_done", W'(div_done), '0);
`ifdef DIVU_DBZ_FLAG_EN
        chk("rst_dbz", W'(div_by_zero), '0);
`endif
        reset = 1'b0;
        tick();

        // 0x69 / 3
        start(32'h69, 32'h3);
        chk("t1_done_low", W'(div_done), '0);
        wait_done("t1", 0, '0);
        chk("t1_done", W'(div_done), 32'd1);
        repeat (3) tick();
        chk("t1_hold_done", W'(div_done), 32'd1);
        chk("t1_hold_quot", quotient, 32'h23);

        // Back-to-back requests, div_done drops on the accepting edge
        start(32'hFFFF_FFFF, 32'h2);
        chk("t2_done_drop", W'(div_done), '0);
        wait_done("t2", 0, 32'h23);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("t3", 0, 32'h7FFF_FFFF);

        // Divide by zero bypass completes on the accepting edge
        start(32'hF000_0000, 32'h0);
        chk("dbz_done", W'(div_done), 32'd1);
        compare_result("dbz");
`ifdef DIVU_DBZ_FLAG_EN
        chk("dbz_flag", W'(div_by_zero), 32'd1);
`endif
        start(32'd7, 32'd2);
`ifdef DIVU_DBZ_FLAG_EN
        chk("dbz_flag_clr", W'(div_by_zero), '0);
`endif
        chk("dbz_next_done_low", W'(div_done), '0);
        wait_done("t7_2", 0, 32'hFFFF_FFFF);

        // Request during BUSY is ignored
        start(32'd100, 32'd7);
        repeat (9) tick();
        a = 32'd9;
        b = 32'd3;
        doDiv = 1'b1;
        tick();
        doDiv = 1'b0;
        chk("busy_done_low", W'(div_done), '0);
        wait_done("busy_ign", 10, 32'd3);
        repeat (2) tick();
        chk("busy_no_restart", W'(div_done), 32'd1);

        // Reset abandons a division in progress
        a = 32'd1000;
        b = 32'd7;
        doDiv = 1'b1;
        tick();
        doDiv = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_quot", quotient, '0);
        chk("abort_rem", remainder, '0);
        chk("abort_done", W'(div_done), '0);
        repeat (25) tick();
        chk("abort_no_result", W'(div_done), '0);
        start(32'd10, 32'd3);
        wait_done("after_abort", 0, '0);

        // Reset wins over a simultaneous request
        reset = 1'b1;
        a = 32'd5;
        b = 32'd0;
        doDiv = 1'b1;
        tick();
        reset = 1'b0;
        doDiv = 1'b0;
        chk("rst_win_done", W'(div_done), '0);
        chk("rst_win_quot", quotient, '0);
        tick();
        chk("rst_win_idle", W'(div_done), '0);

        // Random operands
        prev_q = quotient;
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb & 32'h0000_00FF;
            if (i % 3 == 2) rb = rb & 32'h0000_FFFF;
            if (rb == '0) rb = 32'd1;
            start(ra, rb);
            wait_done("rand", 0, prev_q);
            prev_q = quotient;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
